mips: RTL and testbench
=======================

// Module: mips
// PURPOSE
//  Single-cycle 32-bit MIPS core (datapath + controller), no memories inside.
//  Fetches one instruction per clock from external instruction memory via pc/instr.
//  Accesses external data memory via aluout (address), writedata, memwrite and readdata.
//  Top of the CPU hierarchy; the SoC wrapper attaches imem/dmem.
// PARAMETERS
//  RESET_PC  32'h0000_0000  pc value loaded on reset
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  reset      in   1   synchronous, active-high; sampled on rising clk
//  pc         out  32  current instruction address (imem address)
//  instr      in   32  instruction at pc, combinational from imem
//  memwrite   out  1   dmem write enable (1 only for sw)
//  aluout     out  32  ALU result; dmem address for lw/sw
//  writedata  out  32  rf[rt]; dmem store data
//  readdata   in   32  dmem read data at aluout, combinational
// BEHAVIOUR
//  - Reset (sync, high): pc<=RESET_PC; all 32 regs <=0; no writes occur that cycle.
//  - Regfile: 32x32, 2 combinational reads (rs, rt), 1 write on rising clk; r0 reads 0, writes ignored.
//  - Same-cycle read/write of same reg: read returns the old value.
//  - Fields: op=instr[31:26] rs=[25:21] rt=[20:16] rd=[15:11] funct=[5:0] imm=[15:0].
//  - Sign-extend imm for addi/slti/lw/sw/beq; zero-extend for andi/ori.
//  - R-type (op 000000), dest rd: add 100000, sub 100010, and 100100, or 100101,
//    xor 100110, nor 100111, slt 101010 (signed, result 0/1). Unknown funct = NOP.
//  - I-type, dest rt: addi 001000, slti 001010 (signed), andi 001100, ori 001101.
//  - lw 100011: aluout=rs+simm; rt<=readdata. sw 101011: aluout=rs+simm, memwrite=1, writedata=rf[rt].
//  - beq 000100: aluout=rs-rt; taken if zero; pcsrc=taken (internal).
//  - Next pc: taken ? pc+4+(simm<<2) : pc+4; all adds wrap modulo 2^32, no overflow traps.
//  - Unknown opcode = NOP: no reg write, memwrite=0, pc+4.
//  - aluout/memwrite/writedata are combinational from instr and current reg state; latency 0,
//    architectural state (pc, regs) updates at the next rising clk; CPI=1.
//  - During reset cycle memwrite is forced 0; outputs otherwise follow instr combinationally.
// CONFIGURATION
//  MIPS_JUMP_EN defined: adds j (op 000010): pc<={pc+4[31:28], instr[25:0], 2'b00};
//    no reg write, memwrite=0.
//  MIPS_JUMP_EN undefined: op 000010 decodes as NOP (pc+4).
// TESTING
//  1 reset 1 cycle -> pc=0, all regs 0; next: addi r2,r1,2 -> aluout=2, r2=2 after edge, pc=4.
//  2 r1=5 via addi; andi r2,r1,3 ->1; ori ->5|4=5; slti r2,r1,5 ->0; addi r4,r0,-1 then slti r2,r4,0 ->1.
//  3 r1=6,r2=3: add->9, sub->3, and->2, or->7, xor->5, nor->FFFFFFF8, slt->0; write to r0 leaves r0=0.
//  4 lw r2,6(r1) r1=0, readdata=12345678 -> aluout=6, memwrite=0, r2=12345678;
//    sw r2,6(r1) -> memwrite=1, aluout=6, writedata=12345678, no reg change.
//  5 beq r1,r2,+6 equal at pc=8 -> pc=0x24; unequal -> pc=0xC; offset -1 (FFFF) taken -> pc=pc.
//  6 reset asserted mid-program -> next edge pc=0, regs cleared, memwrite=0 during reset;
//    with MIPS_JUMP_EN, j 0x40 -> pc=0x100.

Source files
------------

// File: rtl/mips.sv
// Single-cycle 32-bit MIPS core: register file, decoder, ALU and next-pc logic; memories are external.
// Defining MIPS_JUMP_EN adds the j instruction; otherwise opcode 000010 executes as a NOP.
module mips #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] aluout,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT
    } alu_op_t;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic [15:0]     imm;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign imm   = instr[15:0];
    assign funct = instr[5:0];

    logic    reg_write;
    logic    dst_rd;
    logic    use_imm;
    logic    zext;
    logic    mem_to_reg;
    logic    mem_wr;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;

    // Main decoder; anything not listed falls through as a NOP
    always_comb begin
        reg_write  = 1'b0;
        dst_rd     = 1'b0;
        use_imm    = 1'b0;
        zext       = 1'b0;
        mem_to_reg = 1'b0;
        mem_wr     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                dst_rd    = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
            end
            OP_SLTI: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
                alu_op    = ALU_SLT;
            end
            OP_ANDI: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
                zext      = 1'b1;
                alu_op    = ALU_AND;
            end
            OP_ORI: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
                zext      = 1'b1;
                alu_op    = ALU_OR;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                use_imm    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                use_imm = 1'b1;
                mem_wr  = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
`ifdef MIPS_JUMP_EN
            OP_J: jump = 1'b1;
`endif
            default: ;
        endcase
    end

    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    // r0 is hardwired to zero on read
    assign rd1 = (rs == '0) ? '0 : rf[rs];
    assign rd2 = (rt == '0) ? '0 : rf[rt];

    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;

    assign imm_ext = zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign src_b   = use_imm ? imm_ext : rd2;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = rd1 + src_b;
            ALU_SUB: alu_result = rd1 - src_b;
            ALU_AND: alu_result = rd1 & src_b;
            ALU_OR:  alu_result = rd1 | src_b;
            ALU_XOR: alu_result = rd1 ^ src_b;
            ALU_NOR: alu_result = ~(rd1 | src_b);
            ALU_SLT: alu_result = XLEN'($signed(rd1) < $signed(src_b));
            default: alu_result = '0;
        endcase
    end

    assign aluout    = alu_result;
    assign writedata = rd2;
    assign memwrite  = mem_wr & ~reset;

    logic [RW-1:0]   wa;
    logic [XLEN-1:0] wd;

    assign wa = dst_rd ? rd : rt;
    assign wd = mem_to_reg ? readdata : alu_result;

    // Register file write port; reads above see the pre-edge value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (reg_write && (wa != '0)) begin
            rf[wa] <= wd;
        end
    end

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] pc_next;
    logic            taken;

    assign pc_plus4      = pc + XLEN'(4);
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign taken         = branch & (alu_result == '0);

    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_mips.sv
// Directed testbench for the single-cycle mips core; acts as imem/dmem by driving instr/readdata per cycle.
module tb_mips;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    mips dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_BAD = 6'b000000;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_pc;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one instruction after the falling edge; it commits at the following rising edge
    task automatic exec(input logic [31:0] i, input logic [31:0] rdat);
        @(negedge clk);
        instr    = i;
        readdata = rdat;
        #1;
        check("pc", pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
    endtask

    // Read a register through the ALU with "or r0, rN, r0"
    task automatic obs(input string tag, input int r, input logic [31:0] e);
        exec(enc_r(r, 0, 0, FN_OR), 32'h0);
        check(tag, aluout, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr = enc_i(OP_SW, 1, 2, 6);
        #1;
        check("rst_memwrite", 32'(memwrite), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_pc   = 32'h0;
        reset    = 1'b1;
        instr    = 32'h0;
        readdata = 32'h0;

        // 1: reset and first instruction
        do_reset();
        obs("rst_r1", 1, 32'h0);
        exec(enc_i(OP_ADDI, 1, 2, 2), 32'h0);
        check("addi_alu", aluout, 32'h2);
        check("addi_mw", 32'(memwrite), 32'h0);
        obs("addi_r2", 2, 32'h2);

        // 2: immediate ops, sign vs zero extension
        exec(enc_i(OP_ADDI, 0, 1, 5), 32'h0);
        exec(enc_i(OP_ANDI, 1, 2, 3), 32'h0);
        check("andi", aluout, 32'h1);
        exec(enc_i(OP_ORI, 1, 2, 4), 32'h0);
        check("ori", aluout, 32'h5);
        exec(enc_i(OP_SLTI, 1, 2, 5), 32'h0);
        check("slti_eq", aluout, 32'h0);
        exec(enc_i(OP_ADDI, 0, 4, 'hFFFF), 32'h0);
        check("addi_neg", aluout, 32'hFFFF_FFFF);
        exec(enc_i(OP_SLTI, 4, 2, 0), 32'h0);
        check("slti_neg", aluout, 32'h1);
        obs("slti_r2", 2, 32'h1);
        exec(enc_i(OP_ANDI, 4, 3, 'hFFFF), 32'h0);
        check("andi_zext", aluout, 32'h0000_FFFF);
        exec(enc_i(OP_ORI, 0, 3, 'h8000), 32'h0);
        check("ori_zext", aluout, 32'h0000_8000);
        obs("ori_r3", 3, 32'h0000_8000);

        // 3: R-type with r1=6, r2=3
        exec(enc_i(OP_ADDI, 0, 1, 6), 32'h0);
        exec(enc_i(OP_ADDI, 0, 2, 3), 32'h0);
        exec(enc_r(1, 2, 3, FN_ADD), 32'h0);
        check("add", aluout, 32'h9);
        obs("add_r3", 3, 32'h9);
        exec(enc_r(1, 2, 3, FN_SUB), 32'h0);
        check("sub", aluout, 32'h3);
        exec(enc_r(1, 2, 3, FN_AND), 32'h0);
        check("and", aluout, 32'h2);
        exec(enc_r(1, 2, 3, FN_OR), 32'h0);
        check("or", aluout, 32'h7);
        exec(enc_r(1, 2, 3, FN_XOR), 32'h0);
        check("xor", aluout, 32'h5);
        exec(enc_r(1, 2, 3, FN_NOR), 32'h0);
        check("nor", aluout, 32'hFFFF_FFF8);
        exec(enc_r(1, 2, 3, FN_SLT), 32'h0);
        check("slt_0", aluout, 32'h0);
        exec(enc_r(2, 1, 3, FN_SLT), 32'h0);
        check("slt_1", aluout, 32'h1);
        exec(enc_r(4, 1, 3, FN_SLT), 32'h0);
        check("slt_signed", aluout, 32'h1);
        exec(enc_r(0, 1, 3, FN_SUB), 32'h0);
        check("sub_wrap", aluout, 32'hFFFF_FFFA);
        exec(enc_r(4, 4, 3, FN_ADD), 32'h0);
        check("add_wrap", aluout, 32'hFFFF_FFFE);
        exec(enc_r(1, 2, 0, FN_ADD), 32'h0);
        check("add_r0_alu", aluout, 32'h9);
        obs("r0_zero", 0, 32'h0);
        exec(enc_i(OP_ADDI, 1, 1, 1), 32'h0);
        check("rw_same", aluout, 32'h7);
        obs("rw_r1", 1, 32'h7);

        // Unknown funct / opcode are NOPs
        exec(enc_r(1, 1, 2, FN_BAD), 32'h0);
        check("badfn_mw", 32'(memwrite), 32'h0);
        obs("badfn_r2", 2, 32'h3);
        exec(enc_i(OP_BAD, 1, 2, 'h55), 32'h0);
        check("badop_mw", 32'(memwrite), 32'h0);
        obs("badop_r2", 2, 32'h3);

        // 4: load/store
        exec(enc_i(OP_ADDI, 0, 1, 0), 32'h0);
        exec(enc_i(OP_LW, 1, 2, 6), 32'h1234_5678);
        check("lw_alu", aluout, 32'h6);
        check("lw_mw", 32'(memwrite), 32'h0);
        obs("lw_r2", 2, 32'h1234_5678);
        exec(enc_i(OP_SW, 1, 2, 6), 32'hDEAD_BEEF);
        check("sw_mw", 32'(memwrite), 32'h1);
        check("sw_alu", aluout, 32'h6);
        check("sw_wd", writedata, 32'h1234_5678);
        obs("sw_r2", 2, 32'h1234_5678);
        exec(enc_i(OP_ADDI, 0, 1, 'h100), 32'h0);
        exec(enc_i(OP_LW, 1, 5, -4), 32'hCAFE_F00D);
        check("lw_neg_alu", aluout, 32'h0000_00FC);
        obs("lw_neg_r5", 5, 32'hCAFE_F00D);

        // 5: branches
        do_reset();
        exec(enc_i(OP_ADDI, 0, 1, 7), 32'h0);
        exec(enc_i(OP_ADDI, 0, 2, 7), 32'h0);
        exec(enc_i(OP_BEQ, 1, 2, 6), 32'h0);
        check("beq_alu", aluout, 32'h0);
        exp_pc = 32'h24;
        exec(enc_i(OP_ADDI, 0, 2, 1), 32'h0);
        exec(enc_i(OP_BEQ, 1, 2, 6), 32'h0);
        check("beq_ne_alu", aluout, 32'h6);
        exec(enc_i(OP_BEQ, 0, 0, 'hFFFF), 32'h0);
        exp_pc = 32'h2C;
        exec(enc_i(OP_BEQ, 1, 2, 0), 32'h0);

        // 6: reset mid-program, then j
        do_reset();
        obs("mid_rst_r1", 1, 32'h0);
        obs("mid_rst_r2", 2, 32'h0);
        exec({OP_J, 26'h40}, 32'h0);
        check("j_mw", 32'(memwrite), 32'h0);
`ifdef MIPS_JUMP_EN
        exp_pc = 32'h100;
`endif
        obs("after_j_r0", 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
